// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared encodings for the data_memory bus arbiter
//
// Purpose: state encoding, owner encoding and default widths used by
// mem_bus_arbiter and rr_arb2.
// Ports: none (package).
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  // Owner / grant identifiers
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin arbiter
//
// Purpose: picks one of two requesters; on contention the one not served
// last wins. The priority pointer moves on every accepted grant.
// Ports:
//   clk       in   rising-edge clock
//   reset     in   asynchronous active-low reset (clears pointer -> m0 first)
//   req[1:0]  in   request vector, bit n = master n
//   grant_en  in   grant is being taken this cycle (pointer may advance)
//   gnt_id    out  selected master id
//   gnt_valid out  at least one request present
module rr_arb2
  import mem_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       gnt_id,
  output logic       gnt_valid
);

  // prio_q holds the id that wins the next contention
  logic prio_q, prio_d;

  always_comb begin
    gnt_valid = |req;
    // Single requester wins outright; req[1] alone selects 1, req[0] alone selects 0
    gnt_id    = (req == 2'b11) ? prio_q : req[1];
    prio_d    = prio_q;
    if (grant_en && gnt_valid) begin
      prio_d = ~gnt_id;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_q <= M0;
    end else begin
      prio_q <= prio_d;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one data_memory port between two masters
//
// Purpose: single-beat req/ack arbitration of m0 (CPU) and m1 (DMA) onto
// data_memory with round-robin grant. All memory pins come straight from
// registers loaded at grant, so they never glitch between owners.
// Ports:
//   clk, reset                     clock, asynchronous active-low reset
//   m{0,1}_req/we/addr/wdata       master request side (held until ack)
//   m{0,1}_ack                     one-cycle completion pulse
//   m{0,1}_rdata                   read data, held after ack
//   mem_addr/mem_wdata/mem_we/mem_re  to data_memory
//   mem_rdata                      from data_memory
//   owner                          granted master (valid while busy)
//   busy                           high outside IDLE
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              busy
);

  // Index of the final WAIT cycle; unused when RD_LAT is 0
  localparam logic [1:0] WAIT_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  logic              grant_en, capture;
  logic              gnt_id, gnt_valid;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .reset     (reset),
    .req       ({m1_req, m0_req}),
    .grant_en  (grant_en),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  // Request mux feeds only register D inputs, never the memory pins directly
  assign sel_we    = gnt_id ? m1_we    : m0_we;
  assign sel_addr  = gnt_id ? m1_addr  : m0_addr;
  assign sel_wdata = gnt_id ? m1_wdata : m0_wdata;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    grant_en = 1'b0;
    capture  = 1'b0;
    mem_we_d = 1'b0;
    mem_re_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        grant_en = 1'b1;
        if (gnt_valid) begin
          state_d  = ST_ISSUE;
          // Strobes are registered here so they are high exactly during ISSUE
          mem_we_d = sel_we;
          mem_re_d = ~sel_we;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else if (RD_LAT == 0) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = WAIT_LAST;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 2'd0) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 2'd0;
      owner_q    <= M0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
      if (grant_en && gnt_valid) begin
        owner_q <= gnt_id;
        we_q    <= sel_we;
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      if (capture) begin
        if (owner_q == M0) begin
          m0_rdata_q <= mem_rdata;
        end else begin
          m1_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign mem_re    = mem_re_q;
  assign m0_ack    = (state_q == ST_DONE) && (owner_q == M0);
  assign m1_ack    = (state_q == ST_DONE) && (owner_q == M1);
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single data_memory port between two bus masters: m0 (CPU core) and m1 (DMA/boot loader).
- Sits between the masters and data_memory. Drives its address, write-data, memwrite and memread pins, and returns read data to whichever master owns the bus.
- Transactions are single-beat, using a req/ack handshake.
- Arbitration is round-robin, with a registered request latch, so the memory pins never glitch between owners.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- RD_LAT, 1, memory read latency in cycles from mem_re to valid mem_rdata (legal 0..3)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request, held until m0_ack
- m0_we  in  1  1 = write, 0 = read; qualified by m0_req
- m0_addr  in  ADDR_W  master 0 address
- m0_wdata  in  DATA_W  master 0 write data
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  DATA_W  read data, valid while m0_ack=1, held afterwards
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as master 0, for master 1
- mem_addr  out  ADDR_W  to data_memory addr
- mem_wdata  out  DATA_W  to data_memory write_data
- mem_we  out  1  to data_memory memwrite
- mem_re  out  1  to data_memory memread
- mem_rdata  in  DATA_W  from data_memory read_data
- owner  out  1  master currently granted (valid while busy)
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (reset=0, asynchronous): all of the following clear immediately.
  - state=IDLE; mem_we=mem_re=0; mem_addr=mem_wdata=0.
  - m0/m1_ack=0; m0/m1_rdata=0; owner=0; busy=0.
  - Round-robin pointer cleared, so m0 has priority on the first contention.
- Reset mid-transaction: the transaction is aborted with no ack, and mem_we drops at once. A master must re-issue its request after reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - Requests are sampled on each rising edge.
  - If only one req is high, that master is granted.
  - If both are high, grant goes to the master not served last (pointer). The pointer updates on every grant.
  - On grant: latch addr, we and wdata into registers; set owner; go to ISSUE.
- ISSUE (1 cycle):
  - mem_addr and mem_wdata come from the latched values.
  - mem_we = latched we; mem_re = !latched we.
  - Next state:
    - write: DONE
    - read with RD_LAT=0: capture mem_rdata at the end of this cycle, then DONE
    - otherwise: WAIT
- WAIT:
  - Counts RD_LAT cycles with mem_re=0 and mem_addr held.
  - On the last WAIT cycle, capture mem_rdata into the owner's rdata register, then go to DONE.
- DONE (1 cycle): the owner's ack=1; next state is IDLE.
- Latency, measured from the edge that samples req in IDLE:
  - write ack is high 2 cycles later;
  - read ack is high (3 + RD_LAT − 1) cycles later, i.e. 3 cycles for RD_LAT=1.
- Handshake rules:
  - req, we, addr and wdata must be stable from req rise until ack.
  - Inputs are latched at grant, so changes made after grant are ignored.
  - A master deasserts req on the edge it sees ack. If req is still high when IDLE samples it, that is a new transaction.
- Back-to-back operation:
  - Minimum bus turnaround is one IDLE cycle between transactions.
  - With both masters requesting continuously, grants strictly alternate.
- The non-owner's ack is always 0. The non-owner's rdata is unchanged.
- The memory pins change only on clock edges, from registers; there are no combinational paths from m*_ inputs to mem_*.
- mem_we and mem_re are never high in the same cycle.

Decomposition:
- Shared package mem_bus_pkg holds:
  - the state encoding (IDLE=0, ISSUE=1, WAIT=2, DONE=3);
  - ADDR_W and DATA_W defaults;
  - the owner encoding M0=0, M1=1.
- One sub-module, rr_arb2: a 2-input round-robin arbiter.
  - Inputs: req[1:0], grant_en.
  - Outputs: gnt_id, gnt_valid.
  - Holds the pointer register, with the same asynchronous active-low reset.
  - The FSM stays in mem_bus_arbiter.

Test Plan:
- Reset check: hold reset=0 mid-read, with m0 reading 0x0010 in WAIT → outputs clear immediately, m0_ack never pulses, and the next transaction completes normally.
- Single write then read (m0 only, RD_LAT=1):
  - Write 0x0010 ← 0xBEEF: mem_we high for exactly 1 cycle with mem_addr=0x0010, mem_wdata=0xBEEF; m0_ack 2 cycles after sampling.
  - Read 0x0010: mem_re for 1 cycle; m0_rdata=0xBEEF with m0_ack 3 cycles after sampling.
- Simultaneous requests:
  - m0 reads 0x0020 while m1 writes 0x0030 ← 0x1234, asserted on the same edge after reset.
  - m0 is served first, then m1. owner sequence is 0,1; each gets exactly one ack, and m1_ack is never high while owner=0.
- Continuous contention: both reqs held high for 8 transactions → grants alternate 0,1,0,1…; no master is granted twice in a row; mem_we and mem_re are never both high.
- Input change after grant: m1 changes addr from 0x0040 to 0x0041 one cycle after grant → memory sees 0x0040 only.
- RD_LAT sweep: run with RD_LAT=0 and RD_LAT=3 → read ack at 2 and 5 cycles after sampling respectively, with correct data from a preloaded pattern (addr XOR 0xA5A5).
